// File: rtl/pkt_deparser_pkg.sv
// Shared channel types, header sizes and FSM states for the L2-L4 packet deparser.
package pkt_deparser_pkg;

   localparam int ETH_HDR_BYTES  = 14;
   localparam int IPV4_HDR_BYTES = 20;
   localparam int TCP_HDR_BYTES  = 20;
   localparam int L2L4_HDR_BYTES = ETH_HDR_BYTES + IPV4_HDR_BYTES + TCP_HDR_BYTES;
   localparam int HDR_BEATS      = L2L4_HDR_BYTES / 8;
   localparam int HDR_TAIL_BYTES = L2L4_HDR_BYTES % 8;

   typedef struct packed {
      logic                          valid;
      logic [ETH_HDR_BYTES*8-1:0]    data;
   } ch_eth_hdr_struct;

   typedef struct packed {
      logic                          valid;
      logic [IPV4_HDR_BYTES*8-1:0]   data;
   } ch_ipv4_hdr_struct;

   typedef struct packed {
      logic                          valid;
      logic [TCP_HDR_BYTES*8-1:0]    data;
   } ch_tcp_hdr_struct;

   typedef struct packed {
      logic        valid;
      logic        sop;
      logic        eop;
      logic [2:0]  empty;
      logic [63:0] data;
   } ch_pkt_stream_struct;

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      PAY,
      FLUSH
   } deparser_state_e;

endpackage

// File: rtl/pkt_deparser_ipv4_csum.sv
// Combinational ones-complement checksum over a 20-byte IPv4 header.
// Feed the header with its checksum word zeroed to generate; feed it intact to verify (result 0 = good).
module ipv4_csum (
   input  logic [159:0] hdr,
   output logic [15:0]  csum
);

   logic [15:0] words [10];
   logic [19:0] sum;
   logic [16:0] fold1;
   logic [15:0] fold2;

   for (genvar gi = 0; gi < 10; gi++) begin : g_word
      assign words[gi] = hdr[159-16*gi -: 16];
   end

   // Ten 16-bit words need at most 4 carry bits; two folds absorb every carry.
   always_comb begin
      sum = '0;
      for (int i = 0; i < 10; i++) begin
         sum = sum + 20'(words[i]);
      end
      fold1 = 17'(sum[15:0]) + 17'(sum[19:16]);
      fold2 = fold1[15:0] + 16'(fold1[16]);
      csum  = ~fold2;
   end

endmodule

// File: rtl/pkt_deparser.sv
// Assembles Ethernet/IPv4/TCP headers plus an optional payload into a 64-bit frame stream,
// realigning the payload behind the 54-byte header through a 6-byte residue register.
module pkt_deparser
   import pkt_deparser_pkg::*;
#(
   parameter bit RECALC_CSUM = 1'b1,
   parameter int CNT_W       = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  ch_eth_hdr_struct    ch_eth_hdr_in,
   output logic                ch_eth_hdr_in_ready,
   input  ch_ipv4_hdr_struct   ch_ipv4_hdr_in,
   output logic                ch_ipv4_hdr_in_ready,
   input  ch_tcp_hdr_struct    ch_tcp_hdr_in,
   output logic                ch_tcp_hdr_in_ready,
   input  ch_pkt_stream_struct ch_pkt_stream_payload_in,
   output logic                ch_pkt_stream_payload_in_ready,
   output ch_pkt_stream_struct ch_pkt_stream_eth_out,
   input  logic                ch_pkt_stream_eth_out_ready,
   output logic [CNT_W-1:0]    pkt_count
);

   deparser_state_e             state_reg;
   logic [L2L4_HDR_BYTES*8-1:0] hdr_sr_reg;
   logic [2:0]                  beat_cnt_reg;
   logic [HDR_TAIL_BYTES*8-1:0] residue_reg;
   logic [2:0]                  flush_empty_reg;
   logic                        no_pay_reg;

   logic        hdr_accept;
   logic        out_xfer;
   logic        pay_xfer;
   logic [3:0]  pay_bytes;
   logic [15:0] csum;
   logic [159:0] ipv4_zeroed;
   logic [159:0] ipv4_final;
   logic [63:0] hdr_beat [HDR_BEATS];
   logic        unused_pay_sop;

   assign hdr_accept = (state_reg == IDLE) && ch_eth_hdr_in.valid &&
                       ch_ipv4_hdr_in.valid && ch_tcp_hdr_in.valid;
   assign ch_eth_hdr_in_ready  = hdr_accept;
   assign ch_ipv4_hdr_in_ready = hdr_accept;
   assign ch_tcp_hdr_in_ready  = hdr_accept;

   assign ch_pkt_stream_payload_in_ready = (state_reg == PAY) && ch_pkt_stream_eth_out_ready;
   assign pay_xfer  = ch_pkt_stream_payload_in.valid && ch_pkt_stream_payload_in_ready;
   assign out_xfer  = ch_pkt_stream_eth_out.valid && ch_pkt_stream_eth_out_ready;
   assign pay_bytes = 4'd8 - {1'b0, ch_pkt_stream_payload_in.empty};
   assign unused_pay_sop = ch_pkt_stream_payload_in.sop;

   assign ipv4_zeroed = {ch_ipv4_hdr_in.data[159:80], 16'h0000, ch_ipv4_hdr_in.data[63:0]};

   ipv4_csum u_csum (
      .hdr  (ipv4_zeroed),
      .csum (csum)
   );

   if (RECALC_CSUM) begin : g_recalc
      assign ipv4_final = {ch_ipv4_hdr_in.data[159:80], csum, ch_ipv4_hdr_in.data[63:0]};
   end else begin : g_pass
      assign ipv4_final = ch_ipv4_hdr_in.data;
   end

   for (genvar gi = 0; gi < HDR_BEATS; gi++) begin : g_hdr_beat
      assign hdr_beat[gi] = hdr_sr_reg[L2L4_HDR_BYTES*8-1-64*gi -: 64];
   end

   always_comb begin
      ch_pkt_stream_eth_out = '0;
      unique case (state_reg)
         HDR: begin
            ch_pkt_stream_eth_out.valid = 1'b1;
            ch_pkt_stream_eth_out.sop   = (beat_cnt_reg == 3'd0);
            ch_pkt_stream_eth_out.data  = hdr_beat[beat_cnt_reg];
         end
         PAY: begin
            // Six held bytes lead; the first two bytes of the incoming beat complete the word.
            ch_pkt_stream_eth_out.valid = ch_pkt_stream_payload_in.valid;
            ch_pkt_stream_eth_out.data  = {residue_reg, ch_pkt_stream_payload_in.data[63:48]};
            if (ch_pkt_stream_payload_in.eop && pay_bytes <= 4'd2) begin
               ch_pkt_stream_eth_out.eop   = 1'b1;
               ch_pkt_stream_eth_out.empty = 3'(4'd2 - pay_bytes);
            end
         end
         FLUSH: begin
            ch_pkt_stream_eth_out.valid = 1'b1;
            ch_pkt_stream_eth_out.eop   = 1'b1;
            ch_pkt_stream_eth_out.empty = flush_empty_reg;
            ch_pkt_stream_eth_out.data  = {residue_reg, 16'h0000};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= IDLE;
         hdr_sr_reg      <= '0;
         beat_cnt_reg    <= '0;
         residue_reg     <= '0;
         flush_empty_reg <= '0;
         no_pay_reg      <= 1'b0;
         pkt_count       <= '0;
      end else begin
         if (out_xfer && ch_pkt_stream_eth_out.eop) begin
            pkt_count <= pkt_count + CNT_W'(1);
         end
         unique case (state_reg)
            IDLE: begin
               if (hdr_accept) begin
                  hdr_sr_reg   <= {ch_eth_hdr_in.data, ipv4_final, ch_tcp_hdr_in.data};
                  no_pay_reg   <= (ch_ipv4_hdr_in.data[143:128] == 16'd40);
                  beat_cnt_reg <= '0;
                  state_reg    <= HDR;
               end
            end
            HDR: begin
               if (out_xfer) begin
                  if (beat_cnt_reg == 3'(HDR_BEATS - 1)) begin
                     residue_reg <= hdr_sr_reg[HDR_TAIL_BYTES*8-1:0];
                     if (no_pay_reg) begin
                        flush_empty_reg <= 3'd2;
                        state_reg       <= FLUSH;
                     end else begin
                        state_reg <= PAY;
                     end
                  end else begin
                     beat_cnt_reg <= beat_cnt_reg + 3'd1;
                  end
               end
            end
            PAY: begin
               if (pay_xfer) begin
                  residue_reg <= ch_pkt_stream_payload_in.data[47:0];
                  if (ch_pkt_stream_payload_in.eop) begin
                     if (pay_bytes <= 4'd2) begin
                        state_reg <= IDLE;
                     end else begin
                        // v-2 payload bytes remain in the residue: empty = 8-(v-2).
                        flush_empty_reg <= 3'(4'd10 - pay_bytes);
                        state_reg       <= FLUSH;
                     end
                  end
               end
            end
            FLUSH: begin
               if (out_xfer) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pkt_deparser.sv
// Scoreboard bench for pkt_deparser: two instances (checksum recomputed / passed through) share stimulus.
module tb_pkt_deparser;
   import pkt_deparser_pkg::*;

   typedef struct packed {
      logic        sop;
      logic        eop;
      logic [2:0]  empty;
      logic [63:0] data;
   } beat_t;

   logic clk = 1'b0;
   logic reset;
   logic out_ready;
   always #5 clk = ~clk;

   ch_eth_hdr_struct    eth_in;
   ch_ipv4_hdr_struct   ip_in;
   ch_tcp_hdr_struct    tcp_in;
   ch_pkt_stream_struct pay_in, out_a, out_b;
   logic eth_rdy_a, ip_rdy_a, tcp_rdy_a, pay_rdy_a;
   logic eth_rdy_b, ip_rdy_b, tcp_rdy_b, pay_rdy_b;
   logic [31:0] cnt_a, cnt_b;

   pkt_deparser #(.RECALC_CSUM(1'b1), .CNT_W(32)) u_dut (
      .clk(clk), .reset(reset),
      .ch_eth_hdr_in(eth_in), .ch_eth_hdr_in_ready(eth_rdy_a),
      .ch_ipv4_hdr_in(ip_in), .ch_ipv4_hdr_in_ready(ip_rdy_a),
      .ch_tcp_hdr_in(tcp_in), .ch_tcp_hdr_in_ready(tcp_rdy_a),
      .ch_pkt_stream_payload_in(pay_in), .ch_pkt_stream_payload_in_ready(pay_rdy_a),
      .ch_pkt_stream_eth_out(out_a), .ch_pkt_stream_eth_out_ready(out_ready),
      .pkt_count(cnt_a)
   );

   pkt_deparser #(.RECALC_CSUM(1'b0), .CNT_W(32)) u_pass (
      .clk(clk), .reset(reset),
      .ch_eth_hdr_in(eth_in), .ch_eth_hdr_in_ready(eth_rdy_b),
      .ch_ipv4_hdr_in(ip_in), .ch_ipv4_hdr_in_ready(ip_rdy_b),
      .ch_tcp_hdr_in(tcp_in), .ch_tcp_hdr_in_ready(tcp_rdy_b),
      .ch_pkt_stream_payload_in(pay_in), .ch_pkt_stream_payload_in_ready(pay_rdy_b),
      .ch_pkt_stream_eth_out(out_b), .ch_pkt_stream_eth_out_ready(out_ready),
      .pkt_count(cnt_b)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          exp_cnt  = 0;
   int          pkt_idx  = 0;
   bit          stall_mode = 1'b0;
   logic        saw_pay_rdy = 1'b0;
   logic        stall_pend  = 1'b0;
   ch_pkt_stream_struct stall_snap;
   beat_t       exp_a[$], exp_b[$];
   logic [7:0]  frame_a[$], frame_b[$];

   function automatic logic [15:0] ref_csum(input logic [159:0] ip);
      logic [31:0] s;
      s = 0;
      for (int i = 0; i < 10; i++) if (i != 5) s += 32'(ip[159-16*i -: 16]);
      while (s[31:16] != 0) s = 32'(s[15:0]) + 32'(s[31:16]);
      return ~s[15:0];
   endfunction

   task automatic push_frame(input bit sel);
      int    n;
      beat_t b;
      n = sel ? frame_b.size() : frame_a.size();
      for (int i = 0; i < n; i += 8) begin
         b       = '0;
         b.sop   = (i == 0);
         b.eop   = (i + 8 >= n);
         b.empty = b.eop ? 3'(i + 8 - n) : 3'd0;
         for (int j = 0; j < 8; j++)
            if (i + j < n) b.data[63-8*j -: 8] = sel ? frame_b[i+j] : frame_a[i+j];
         if (sel) exp_b.push_back(b); else exp_a.push_back(b);
      end
   endtask

   task automatic check_pop(input bit sel);
      beat_t got, want;
      int    depth;
      got   = sel ? {out_b.sop, out_b.eop, out_b.empty, out_b.data}
                  : {out_a.sop, out_a.eop, out_a.empty, out_a.data};
      depth = sel ? exp_b.size() : exp_a.size();
      n_checks++;
      assert (depth != 0) else begin
         n_fail++;
         $error("FAIL unexpected_beat inst=%0d observed=%h expected=none", sel, got);
      end
      if (depth != 0) begin
         want = sel ? exp_b.pop_front() : exp_a.pop_front();
         n_checks++;
         assert (got === want) else begin
            n_fail++;
            $error("FAIL beat inst=%0d observed=%h expected=%h", sel, got, want);
         end
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         stall_pend = 1'b0;
      end else begin
         if (pay_rdy_a) saw_pay_rdy = 1'b1;
         if (stall_pend) begin
            n_checks++;
            assert (out_a === stall_snap) else begin
               n_fail++;
               $error("FAIL stall_hold observed=%h expected=%h", out_a, stall_snap);
            end
         end
         stall_pend = out_a.valid && !out_ready;
         stall_snap = out_a;
         if (pay_in.valid) begin
            n_checks++;
            assert (!pay_rdy_a || out_ready) else begin
               n_fail++;
               $error("FAIL pay_ready_track observed=%b expected=%b", pay_rdy_a, out_ready);
            end
         end
         if (out_a.valid && out_ready) check_pop(1'b0);
         if (out_b.valid && out_ready) check_pop(1'b1);
      end
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Drives one packet; abort_at >= 0 asserts reset after that many payload beats.
   task automatic send_pkt(input logic [159:0] ip, input int pay_len,
                           input logic [15:0] csum_exp, input int abort_at);
      logic [111:0] eth;
      logic [159:0] tcp, ip_fix;
      logic [7:0]   pb;
      int           cyc;
      pkt_idx++;
      eth    = {48'h0200_0000_0001 + 48'(pkt_idx), 48'h02aa_bbcc_ddee, 16'h0800};
      tcp    = {16'd1234, 16'd80, 32'h1000_0000 + 32'(pkt_idx), 32'h0, 16'h5018, 16'hffff, 32'h0};
      ip_fix = ip;
      ip_fix[79:64] = csum_exp;
      frame_a = {};
      frame_b = {};
      for (int i = 0; i < 14; i++) begin
         frame_a.push_back(eth[111-8*i -: 8]); frame_b.push_back(eth[111-8*i -: 8]);
      end
      for (int i = 0; i < 20; i++) begin
         frame_a.push_back(ip_fix[159-8*i -: 8]); frame_b.push_back(ip[159-8*i -: 8]);
      end
      for (int i = 0; i < 20; i++) begin
         frame_a.push_back(tcp[159-8*i -: 8]); frame_b.push_back(tcp[159-8*i -: 8]);
      end
      for (int i = 0; i < pay_len; i++) begin
         pb = 8'($urandom);
         frame_a.push_back(pb); frame_b.push_back(pb);
      end
      push_frame(1'b0);
      push_frame(1'b1);

      @(posedge clk); #1;
      eth_in = {1'b1, eth};
      ip_in  = {1'b1, ip};
      tcp_in = {1'b1, tcp};
      cyc = 0;
      do begin @(negedge clk); cyc++; end
      while (!(eth_rdy_a && ip_rdy_a && tcp_rdy_a) && cyc < 50);
      n_checks++;
      assert (eth_rdy_a && ip_rdy_a && tcp_rdy_a) else begin
         n_fail++;
         $error("FAIL hdr_accept observed=%b%b%b expected=111", eth_rdy_a, ip_rdy_a, tcp_rdy_a);
      end
      @(posedge clk); #1;
      eth_in = '0; ip_in = '0; tcp_in = '0;

      for (int i = 0; i < pay_len; i += 8) begin
         if (i / 8 == abort_at) begin
            reset = 1'b1;
            #1;
            n_checks++;
            assert (out_a.valid === 1'b0 && cnt_a === 32'd0 && pay_rdy_a === 1'b0) else begin
               n_fail++;
               $error("FAIL reset_mid_pay observed=v%b cnt%0d rdy%b expected=v0 cnt0 rdy0",
                      out_a.valid, cnt_a, pay_rdy_a);
            end
            exp_a.delete(); exp_b.delete();
            pay_in = '0;
            repeat (2) @(negedge clk);
            reset   = 1'b0;
            exp_cnt = 0;
            return;
         end
         pay_in       = '0;
         pay_in.valid = 1'b1;
         pay_in.sop   = (i == 0);
         pay_in.eop   = (i + 8 >= pay_len);
         pay_in.empty = pay_in.eop ? 3'(i + 8 - pay_len) : 3'd0;
         for (int j = 0; j < 8; j++)
            if (i + j < pay_len) pay_in.data[63-8*j -: 8] = frame_a[54+i+j];
         cyc = 0;
         do begin @(negedge clk); cyc++; end while (!pay_rdy_a && cyc < 300);
         n_checks++;
         assert (pay_rdy_a) else begin
            n_fail++;
            $error("FAIL pay_accept_timeout observed=%b expected=1", pay_rdy_a);
         end
         @(posedge clk); #1;
      end
      pay_in = '0;
   endtask

   task automatic drain();
      int cyc;
      cyc = 0;
      while ((exp_a.size() != 0 || exp_b.size() != 0) && cyc < 400) begin
         @(negedge clk); cyc++;
      end
      n_checks++;
      assert (exp_a.size() == 0 && exp_b.size() == 0) else begin
         n_fail++;
         $error("FAIL drain_timeout observed=%0d/%0d expected=0/0", exp_a.size(), exp_b.size());
      end
      @(posedge clk); #1;
      exp_cnt++;
      n_checks++;
      assert (cnt_a === 32'(exp_cnt) && cnt_b === 32'(exp_cnt)) else begin
         n_fail++;
         $error("FAIL pkt_count observed=%0d/%0d expected=%0d", cnt_a, cnt_b, exp_cnt);
      end
   endtask

   function automatic logic [159:0] mk_ip(input int pay_len);
      logic [159:0] ip;
      ip = {16'h4500, 16'(40 + pay_len), 16'h1c46, 16'h4000, 16'h4006, 16'hbeef,
            32'h0a00_0001, 32'h0a00_0002 + 32'(pay_len)};
      return ip;
   endfunction

   initial begin
      logic [159:0] ip;
      reset  = 1'b1;
      eth_in = '0; ip_in = '0; tcp_in = '0; pay_in = '0;
      repeat (3) @(posedge clk); #1;
      n_checks++;
      assert ({eth_rdy_a, ip_rdy_a, tcp_rdy_a, pay_rdy_a} === 4'b0) else begin
         n_fail++;
         $error("FAIL reset_readies observed=%b expected=0000", {eth_rdy_a, ip_rdy_a, tcp_rdy_a, pay_rdy_a});
      end
      n_checks++;
      assert (out_a === '0 && cnt_a === 32'd0) else begin
         n_fail++;
         $error("FAIL reset_out observed=%h cnt=%0d expected=0 cnt=0", out_a, cnt_a);
      end
      @(negedge clk); reset = 1'b0;

      // header-only frame
      saw_pay_rdy = 1'b0;
      ip = mk_ip(0);
      send_pkt(ip, 0, ref_csum(ip), -1);
      drain();
      n_checks++;
      assert (saw_pay_rdy === 1'b0) else begin
         n_fail++;
         $error("FAIL hdr_only_pay_ready observed=%b expected=0", saw_pay_rdy);
      end
      $display("pkt %0d: header-only done, count=%0d", pkt_idx, cnt_a);

      ip = mk_ip(2);
      send_pkt(ip, 2, ref_csum(ip), -1);
      drain();
      $display("pkt %0d: 2-byte payload done, count=%0d", pkt_idx, cnt_a);

      ip = mk_ip(11);
      send_pkt(ip, 11, ref_csum(ip), -1);
      drain();
      $display("pkt %0d: 11-byte payload done, count=%0d", pkt_idx, cnt_a);

      ip = {16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011, 16'h1234,
            16'hc0a8, 16'h0001, 16'hc0a8, 16'h00c7};
      send_pkt(ip, 75, 16'hb861, -1);
      drain();
      $display("pkt %0d: checksum example done, count=%0d", pkt_idx, cnt_a);

      stall_mode = 1'b1;
      for (int k = 0; k < 3; k++) begin
         ip = mk_ip(64 - k);
         send_pkt(ip, 64 - k, ref_csum(ip), -1);
         drain();
         $display("pkt %0d: backpressured %0d-byte payload done, count=%0d", pkt_idx, 64 - k, cnt_a);
      end
      stall_mode = 1'b0;

      ip = mk_ip(64);
      send_pkt(ip, 64, ref_csum(ip), 2);
      $display("pkt %0d: reset asserted in payload, count=%0d", pkt_idx, cnt_a);

      ip = mk_ip(5);
      send_pkt(ip, 5, ref_csum(ip), -1);
      drain();
      $display("pkt %0d: post-reset 5-byte payload done, count=%0d", pkt_idx, cnt_a);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
